// File: rtl/mem_ctrl.sv
// Byte-serial load/store controller between the MEM stage and an 8-bit synchronous RAM.
// Accesses of 1, 2 or 4 bytes are issued one byte per cycle; loads are assembled and extended.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic [31:0] ram_addr_o,
   output logic        ram_we_o,
   output logic [7:0]  ram_dout_o,
   input  logic [7:0]  ram_din_i
);

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

   state_e      state_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] asm_q;
   logic        unsigned_q;
   logic [2:0]  n_q;
   logic [2:0]  k_q;

   logic [2:0]  n_req;
   logic [2:0]  k_nxt;
   logic [2:0]  k_prev;
   logic [31:0] addr_nxt;
   logic [7:0]  wbyte_nxt;
   logic [31:0] asm_merged;
   logic [31:0] load_ext;
   logic        sign8;
   logic        sign16;

   always_comb begin
      unique case (size_i)
         2'b00:   n_req = 3'd1;
         2'b01:   n_req = 3'd2;
         default: n_req = 3'd4;
      endcase
   end

   assign k_nxt    = k_q + 3'd1;
   assign k_prev   = k_q - 3'd1;
   assign addr_nxt = addr_q + {29'd0, k_nxt};

   always_comb begin
      unique case (k_nxt[1:0])
         2'd0:    wbyte_nxt = wdata_q[7:0];
         2'd1:    wbyte_nxt = wdata_q[15:8];
         2'd2:    wbyte_nxt = wdata_q[23:16];
         default: wbyte_nxt = wdata_q[31:24];
      endcase
   end

   // Byte presented one cycle earlier arrives now; k = 0 has nothing to capture yet.
   always_comb begin
      asm_merged = asm_q;
      if (k_q != 3'd0) begin
         unique case (k_prev[1:0])
            2'd0:    asm_merged[7:0]   = ram_din_i;
            2'd1:    asm_merged[15:8]  = ram_din_i;
            2'd2:    asm_merged[23:16] = ram_din_i;
            default: asm_merged[31:24] = ram_din_i;
         endcase
      end
   end

   assign sign8  = ~unsigned_q & asm_merged[7];
   assign sign16 = ~unsigned_q & asm_merged[15];

   always_comb begin
      unique case (n_q)
         3'd1:    load_ext = {{24{sign8}}, asm_merged[7:0]};
         3'd2:    load_ext = {{16{sign16}}, asm_merged[15:0]};
         default: load_ext = asm_merged;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         asm_q      <= '0;
         unsigned_q <= 1'b0;
         n_q        <= '0;
         k_q        <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         rdata_o    <= '0;
         ram_addr_o <= '0;
         ram_we_o   <= 1'b0;
         ram_dout_o <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_o <= 1'b0;
               if (req_i) begin
                  addr_q     <= addr_i;
                  wdata_q    <= wdata_i;
                  unsigned_q <= unsigned_i;
                  n_q        <= n_req;
                  k_q        <= 3'd0;
                  asm_q      <= '0;
                  busy_o     <= 1'b1;
                  ram_addr_o <= addr_i;
                  if (we_i) begin
                     state_q    <= StWrite;
                     ram_we_o   <= 1'b1;
                     ram_dout_o <= wdata_i[7:0];
                  end else begin
                     state_q <= StRead;
                  end
               end
            end
            StWrite: begin
               if (k_q == n_q - 3'd1) begin
                  state_q    <= StDone;
                  done_o     <= 1'b1;
                  ram_we_o   <= 1'b0;
                  ram_addr_o <= '0;
                  ram_dout_o <= '0;
               end else begin
                  k_q        <= k_nxt;
                  ram_addr_o <= addr_nxt;
                  ram_dout_o <= wbyte_nxt;
               end
            end
            StRead: begin
               asm_q <= asm_merged;
               if (k_q == n_q) begin
                  state_q    <= StDone;
                  done_o     <= 1'b1;
                  rdata_o    <= load_ext;
                  ram_addr_o <= '0;
               end else begin
                  k_q        <= k_nxt;
                  // Final read cycle only collects the last byte; no address goes out.
                  ram_addr_o <= (k_nxt < n_q) ? addr_nxt : 32'd0;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a small synchronous byte RAM model.
// Each task drives one scenario and compares cycle-by-cycle against hand-computed values.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] wdata_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] rdata_o;
   logic [31:0] ram_addr_o;
   logic        ram_we_o;
   logic [7:0]  ram_dout_o;
   logic [7:0]  ram_din_i;

   int total = 0;
   int bad   = 0;

   // RAM model indexed by addr[9:0]; preload port used only while the DUT is idle.
   logic [7:0] mem [0:1023];
   logic       pre_we = 1'b0;
   logic [9:0] pre_addr = '0;
   logic [7:0] pre_data = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we_o) mem[ram_addr_o[9:0]] <= ram_dout_o;
      else if (pre_we) mem[pre_addr] <= pre_data;
      ram_din_i <= mem[ram_addr_o[9:0]];
   end

   mem_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .size_i     (size_i),
      .unsigned_i (unsigned_i),
      .wdata_i    (wdata_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .rdata_o    (rdata_o),
      .ram_addr_o (ram_addr_o),
      .ram_we_o   (ram_we_o),
      .ram_dout_o (ram_dout_o),
      .ram_din_i  (ram_din_i)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_we   = 1'b0;
   endtask

   // Present a request for one cycle; returns in cycle 1 (after the acceptance edge).
   task automatic start(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
      req_i      = 1'b1;
      we_i       = we;
      addr_i     = a;
      size_i     = sz;
      unsigned_i = uns;
      wdata_i    = wd;
      tick();
      req_i      = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      req_i = 1'b0;
      tick();
      tick();
      total += 6;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy_o); end
      if (done_o !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", done_o); end
      if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset rdata got=%h want=0", rdata_o); end
      if (ram_we_o !== 1'b0) begin bad++; $display("FAIL reset we got=%b want=0", ram_we_o); end
      if (ram_addr_o !== 32'h0) begin
         bad++; $display("FAIL reset addr got=%h want=0", ram_addr_o);
      end
      if (ram_dout_o !== 8'h0) begin
         bad++; $display("FAIL reset dout got=%h want=0", ram_dout_o);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_store_word();
      logic [31:0] wd;
      logic [31:0] exp_addr;
      logic [7:0]  exp_dout;
      logic        exp_we;
      wd = 32'hDEADBEEF;
      start(1'b1, 32'h100, 2'b10, 1'b0, wd);
      for (int c = 1; c <= 5; c++) begin
         exp_we   = (c <= 4);
         exp_addr = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
         exp_dout = (c <= 4) ? 8'(wd >> (8 * (c - 1))) : 8'h0;
         total += 5;
         if (ram_we_o !== exp_we) begin
            bad++; $display("FAIL store_word we c=%0d got=%b want=%b", c, ram_we_o, exp_we);
         end
         if (ram_addr_o !== exp_addr) begin
            bad++; $display("FAIL store_word addr c=%0d got=%h want=%h", c, ram_addr_o, exp_addr);
         end
         if (ram_dout_o !== exp_dout) begin
            bad++; $display("FAIL store_word dout c=%0d got=%h want=%h", c, ram_dout_o, exp_dout);
         end
         if (done_o !== (c == 5)) begin
            bad++; $display("FAIL store_word done c=%0d got=%b", c, done_o);
         end
         if (busy_o !== 1'b1) begin
            bad++; $display("FAIL store_word busy c=%0d got=%b want=1", c, busy_o);
         end
         tick();
      end
      total += 3;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         bad++; $display("FAIL store_word idle busy=%b done=%b want 0/0", busy_o, done_o);
      end
      if ({mem[259], mem[258], mem[257], mem[256]} !== 32'hDEADBEEF) begin
         bad++; $display("FAIL store_word ram got=%h want=deadbeef",
                         {mem[259], mem[258], mem[257], mem[256]});
      end
      if (rdata_o !== 32'h0) begin
         bad++; $display("FAIL store_word rdata got=%h want=0", rdata_o);
      end
   endtask

   task automatic test_load_byte(input logic uns, input logic [31:0] want);
      preload(10'h20, 8'h80);
      start(1'b0, 32'h20, 2'b00, uns, 32'h0);
      total += 3;
      if (ram_addr_o !== 32'h20 || ram_we_o !== 1'b0) begin
         bad++; $display("FAIL load_byte c1 addr=%h we=%b want 20/0", ram_addr_o, ram_we_o);
      end
      tick();
      if (ram_addr_o !== 32'h0 || done_o !== 1'b0) begin
         bad++; $display("FAIL load_byte c2 addr=%h done=%b want 0/0", ram_addr_o, done_o);
      end
      tick();
      if (done_o !== 1'b1 || rdata_o !== want || busy_o !== 1'b1) begin
         bad++; $display("FAIL load_byte c3 done=%b busy=%b rdata=%h want 1/1/%h",
                         done_o, busy_o, rdata_o, want);
      end
      tick();
      total += 1;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || rdata_o !== want) begin
         bad++; $display("FAIL load_byte c4 done=%b busy=%b rdata=%h want 0/0/%h",
                         done_o, busy_o, rdata_o, want);
      end
   endtask

   task automatic test_load_half_misaligned();
      preload(10'h41, 8'h34);
      preload(10'h42, 8'h92);
      start(1'b0, 32'h41, 2'b01, 1'b0, 32'h0);
      total += 4;
      if (ram_addr_o !== 32'h41) begin
         bad++; $display("FAIL load_half c1 addr got=%h want=41", ram_addr_o);
      end
      tick();
      if (ram_addr_o !== 32'h42) begin
         bad++; $display("FAIL load_half c2 addr got=%h want=42", ram_addr_o);
      end
      tick();
      if (ram_addr_o !== 32'h0 || done_o !== 1'b0) begin
         bad++; $display("FAIL load_half c3 addr=%h done=%b want 0/0", ram_addr_o, done_o);
      end
      tick();
      if (done_o !== 1'b1 || rdata_o !== 32'hFFFF9234) begin
         bad++; $display("FAIL load_half c4 done=%b rdata=%h want 1/ffff9234", done_o, rdata_o);
      end
      tick();
   endtask

   task automatic test_store_wrap();
      start(1'b1, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0000A1B2);
      total += 4;
      if (ram_we_o !== 1'b1 || ram_addr_o !== 32'hFFFFFFFF || ram_dout_o !== 8'hB2) begin
         bad++; $display("FAIL wrap c1 we=%b addr=%h dout=%h want 1/ffffffff/b2",
                         ram_we_o, ram_addr_o, ram_dout_o);
      end
      tick();
      if (ram_we_o !== 1'b1 || ram_addr_o !== 32'h0 || ram_dout_o !== 8'hA1) begin
         bad++; $display("FAIL wrap c2 we=%b addr=%h dout=%h want 1/0/a1",
                         ram_we_o, ram_addr_o, ram_dout_o);
      end
      tick();
      if (done_o !== 1'b1 || ram_we_o !== 1'b0 || rdata_o !== 32'hFFFF9234) begin
         bad++; $display("FAIL wrap c3 done=%b we=%b rdata=%h want 1/0/ffff9234",
                         done_o, ram_we_o, rdata_o);
      end
      tick();
      if (mem[1023] !== 8'hB2 || mem[0] !== 8'hA1) begin
         bad++; $display("FAIL wrap ram top=%h zero=%h want b2/a1", mem[1023], mem[0]);
      end
   endtask

   task automatic test_req_while_busy();
      int done_cnt = 0;
      int done_at  = 0;
      int we_cnt   = 0;
      start(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
      we_i    = 1'b1;
      addr_i  = 32'h200;
      wdata_i = 32'h11223344;
      for (int c = 1; c <= 10; c++) begin
         req_i = (c == 2 || c == 3 || c == 6);
         if (done_o) begin done_cnt++; done_at = c; end
         if (ram_we_o) we_cnt++;
         tick();
      end
      req_i = 1'b0;
      total += 4;
      if (done_cnt != 1 || done_at != 6) begin
         bad++; $display("FAIL busy_req done pulses=%0d at=%0d want 1 at 6", done_cnt, done_at);
      end
      if (we_cnt != 0) begin
         bad++; $display("FAIL busy_req write cycles got=%0d want=0", we_cnt);
      end
      if (busy_o !== 1'b0) begin
         bad++; $display("FAIL busy_req busy after got=%b want=0", busy_o);
      end
      if (rdata_o !== 32'hDEADBEEF) begin
         bad++; $display("FAIL busy_req rdata got=%h want=deadbeef", rdata_o);
      end
   endtask

   task automatic test_reset_mid_load();
      int done_cnt = 0;
      start(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
      tick();
      tick();
      total += 1;
      if (ram_addr_o !== 32'h102) begin
         bad++; $display("FAIL rst_mid k2 addr got=%h want=102", ram_addr_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total += 2;
      if (busy_o !== 1'b0 || rdata_o !== 32'h0 || ram_addr_o !== 32'h0 || done_o !== 1'b0) begin
         bad++; $display("FAIL rst_mid after busy=%b rdata=%h addr=%h done=%b want 0/0/0/0",
                         busy_o, rdata_o, ram_addr_o, done_o);
      end
      for (int c = 0; c < 8; c++) begin
         if (done_o) done_cnt++;
         tick();
      end
      if (done_cnt != 0) begin
         bad++; $display("FAIL rst_mid done pulses got=%0d want=0", done_cnt);
      end
   endtask

   task automatic test_req_with_reset();
      rst   = 1'b1;
      req_i = 1'b1;
      we_i  = 1'b0;
      addr_i = 32'h20;
      size_i = 2'b00;
      tick();
      rst   = 1'b0;
      req_i = 1'b0;
      tick();
      total += 1;
      if (busy_o !== 1'b0 || ram_addr_o !== 32'h0) begin
         bad++; $display("FAIL req_rst busy=%b addr=%h want 0/0", busy_o, ram_addr_o);
      end
   endtask

   task automatic test_back_to_back();
      start(1'b1, 32'h30, 2'b00, 1'b0, 32'h0000005A);
      total += 5;
      if (ram_we_o !== 1'b1 || ram_addr_o !== 32'h30 || ram_dout_o !== 8'h5A) begin
         bad++; $display("FAIL b2b c1 we=%b addr=%h dout=%h want 1/30/5a",
                         ram_we_o, ram_addr_o, ram_dout_o);
      end
      tick();
      if (done_o !== 1'b1) begin bad++; $display("FAIL b2b c2 done got=%b want=1", done_o); end
      // Load presented during DONE must be dropped, then accepted when re-presented in IDLE.
      req_i = 1'b1;
      we_i  = 1'b0;
      size_i = 2'b00;
      unsigned_i = 1'b0;
      tick();
      if (busy_o !== 1'b0 || ram_addr_o !== 32'h0) begin
         bad++; $display("FAIL b2b c3 busy=%b addr=%h want 0/0", busy_o, ram_addr_o);
      end
      tick();
      req_i = 1'b0;
      if (busy_o !== 1'b1 || ram_addr_o !== 32'h30) begin
         bad++; $display("FAIL b2b c4 busy=%b addr=%h want 1/30", busy_o, ram_addr_o);
      end
      tick();
      tick();
      if (done_o !== 1'b1 || rdata_o !== 32'h0000005A) begin
         bad++; $display("FAIL b2b c6 done=%b rdata=%h want 1/0000005a", done_o, rdata_o);
      end
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      req_i      = 1'b0;
      we_i       = 1'b0;
      addr_i     = '0;
      size_i     = '0;
      unsigned_i = 1'b0;
      wdata_i    = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      test_reset();
      test_store_word();
      test_load_byte(1'b0, 32'hFFFFFF80);
      test_load_byte(1'b1, 32'h00000080);
      test_load_half_misaligned();
      test_store_wrap();
      test_req_while_busy();
      test_reset_mid_load();
      test_req_with_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have the ports below, one per line as name, direction, width, meaning.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  1  load/store request from the MEM stage; sampled only in IDLE.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address of the access.
- size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = word.
- unsigned_i  in  1  1 = zero-extend the load result, 0 = sign-extend.
- wdata_i  in  32  store data, little-endian, low bytes used.
- busy_o  out  1  high in every state except IDLE; drives the pipeline stall.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result.
- ram_addr_o  out  32  byte address to the RAM.
- ram_we_o  out  1  RAM byte write enable.
- ram_dout_o  out  8  write byte to the RAM.
- ram_din_i  in  8  read byte from the RAM; valid one cycle after its address is presented.

Function
REQ-002 SHALL use the states IDLE, WRITE, READ and DONE, with all outputs registered.
REQ-003 Request acceptance (IDLE, req_i=1):
- latch addr_i, we_i, size_i, unsigned_i and wdata_i;
- set byte count N = 1, 2 or 4 from size_i (size 11 treated as word, N=4);
- clear index k;
- next state: WRITE if we_i=1, otherwise READ.
REQ-004 req_i SHALL be ignored in WRITE, READ and DONE; there is no queueing.
REQ-005 WRITE, for k = 0..N-1, one cycle each:
- ram_we_o = 1;
- ram_addr_o = latched addr + k;
- ram_dout_o = wdata[8k+7:8k].
After byte N-1 the next state is DONE.
REQ-006 READ, for k = 0..N (N+1 cycles), with ram_we_o = 0 throughout:
- for k < N: ram_addr_o = addr + k;
- for k >= 1: capture ram_din_i into assembly byte k-1.
After k = N the next state is DONE.
REQ-007 Address arithmetic SHALL be 32-bit modulo; 0xFFFFFFFF + 1 wraps to 0x00000000. No alignment check is made; misaligned accesses proceed byte by byte.
REQ-008 DONE SHALL last exactly one cycle:
- done_o = 1;
- for a load, rdata_o = assembled value, extended from bit 8N-1 per unsigned_i;
- next state: IDLE.
REQ-009 rdata_o SHALL hold its value until the next load reaches DONE; stores leave rdata_o unchanged.
REQ-010 Outside the RAM-driving cycles:
- in IDLE and DONE: ram_we_o = 0, ram_addr_o = 0, ram_dout_o = 0;
- in READ cycle k = N: ram_addr_o = 0.
REQ-011 busy_o SHALL be 1 from the cycle after acceptance through DONE inclusive, and 0 in IDLE.
REQ-012 Latency, with the acceptance edge as cycle 0:
- store: done_o high in cycle N+1;
- load: done_o high in cycle N+2.
REQ-013 A request arriving in the same cycle as DONE SHALL be ignored; the requester re-presents it once busy_o = 0.

Reset
REQ-014 While rst = 1 at a rising edge, the block SHALL:
- go to IDLE;
- drive busy_o = 0, done_o = 0, rdata_o = 0;
- drive ram_we_o = 0, ram_addr_o = 0, ram_dout_o = 0;
- clear all latched request fields.
REQ-015 A reset in mid-operation SHALL abort the access with no done_o pulse; any RAM bytes already written remain written.
REQ-016 req_i asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-017 Store word: addr 0x100, wdata 0xDEADBEEF.
- Cycles 1-4 write 0xEF, 0xBE, 0xAD, 0xDE to 0x100-0x103, with ram_we_o = 1 in exactly those cycles.
- done_o is high in cycle 5.
- busy_o is high in cycles 1-5.
REQ-018 Signed byte load: RAM[0x20] = 0x80, size 00, unsigned_i = 0.
- rdata_o = 0xFFFFFF80 and done_o = 1 in cycle 3.
- Repeating with unsigned_i = 1 gives 0x00000080.
REQ-019 Signed half load: RAM[0x41] = 0x34, RAM[0x42] = 0x92, addr 0x41 (misaligned).
- Addresses 0x41 then 0x42 are issued.
- rdata_o = 0xFFFF9234 in cycle 4.
REQ-020 Address wrap: store half 0xA1B2 at 0xFFFFFFFF.
- 0xB2 is written to 0xFFFFFFFF, then 0xA1 to 0x00000000.
REQ-021 Request while busy: req_i pulses during an in-flight word load.
- It is ignored: exactly one done_o pulse occurs, and busy_o = 0 afterwards.
REQ-022 Reset mid-load: rst asserted during READ cycle k = 2.
- Next cycle: IDLE, busy_o = 0, rdata_o = 0, ram_addr_o = 0.
- No done_o pulse occurs.
